datapath_sequencer: RTL and testbench

Control FSM for the Simple RISC Machine datapath. It fetches an instruction from memory into the instruction register and decodes it. It then steps the datapath through the register-read, ALU and write-back cycles, and the memory-access cycles, for MOV, ALU, LDR, STR and HALT. It sits between the instruction register and memory on one side and the datapath control inputs on the other, and it also drives PC and data-address register control.

---
 rtl/datapath_sequencer_pkg.sv | 79 +++++++
 rtl/datapath_sequencer_instr_decoder.sv | 24 ++
 rtl/datapath_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// Shared encodings for the Simple RISC Machine datapath sequencer: states,
// opcode/op constants, memory and write-back selects, control bundle.
package datapath_sequencer_pkg;

    typedef enum logic [4:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG,
        S_ADDR,
        S_LOAD_ADDR,
        S_MEM_RD,
        S_WRITE_MDATA,
        S_GET_RD,
        S_STR_PASS,
        S_MEM_WR,
        S_HALT
    } state_t;

    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_MVN     = 2'b11;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_LDST    = 2'b00;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_RD   = 2'b01;
    localparam logic [1:0] MEM_WR   = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM   = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] sh;
        logic [2:0] rm;
    } instr_fields_t;

    typedef struct packed {
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/datapath_sequencer_instr_decoder.sv
// Splits the instruction register into its fields and sign-extends the
// 5-bit and 8-bit immediates.
module instr_decoder
    import datapath_sequencer_pkg::*;
(
    input  logic [15:0]   instr,
    output instr_fields_t fields,
    output logic [15:0]   sximm5,
    output logic [15:0]   sximm8
);

    always_comb begin
        fields.opcode = instr[15:13];
        fields.op     = instr[12:11];
        fields.rn     = instr[10:8];
        fields.rd     = instr[7:5];
        fields.sh     = instr[4:3];
        fields.rm     = instr[2:0];
    end

    assign sximm5 = {{11{instr[4]}}, instr[4:0]};
    assign sximm8 = {{8{instr[7]}}, instr[7:0]};

endmodule

// File: rtl/datapath_sequencer.sv
// Control FSM stepping the datapath through fetch, decode, execute and memory
// cycles; outputs are registered from the state being entered.
//
// state       | meaning
// RST         | PC <- 0
// IF1         | read memory at PC
// IF2         | read memory at PC, IR captures data
// UPDATE_PC   | PC <- PC+1
// DECODE      | route on opcode/op
// WRITE_IMM   | Rn <- sximm8
// GET_A       | A <- Rn
// GET_B       | B <- Rm
// ALU         | C <- ALU result, or status only for CMP
// WRITE_REG   | Rd <- C
// ADDR        | C <- Rn + sximm5
// LOAD_ADDR   | data-address register <- C
// MEM_RD      | read memory at data address
// WRITE_MDATA | Rd <- mdata
// GET_RD      | B <- Rd
// STR_PASS    | C <- B unshifted
// MEM_WR      | write C to data address
// HALT        | stopped until reset
module datapath_sequencer
    import datapath_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        addr_sel,
    output logic        load_addr,
    output logic [1:0]  mem_cmd,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        halted
);

    instr_fields_t fields;
    state_t        state;
    ctrl_t         ctrl;

    instr_decoder u_instr_decoder (
        .instr  (instr),
        .fields (fields),
        .sximm5 (sximm5),
        .sximm8 (sximm8)
    );

    function automatic state_t next_state(input state_t s, input instr_fields_t f);
        state_t n;
        n = S_RST;
        case (s)
            S_RST:       n = S_IF1;
            S_IF1:       n = S_IF2;
            S_IF2:       n = S_UPDATE_PC;
            S_UPDATE_PC: n = S_DECODE;
            S_DECODE: begin
                if (f.opcode == OPC_MOV && f.op == OP_MOV_IMM)
                    n = S_WRITE_IMM;
                else if ((f.opcode == OPC_MOV && f.op == OP_MOV_REG) ||
                         (f.opcode == OPC_ALU && f.op == OP_MVN))
                    n = S_GET_B;
                else if (f.opcode == OPC_ALU ||
                         (f.opcode == OPC_LDR && f.op == OP_LDST) ||
                         (f.opcode == OPC_STR && f.op == OP_LDST))
                    n = S_GET_A;
                else if (f.opcode == OPC_HALT)
                    n = S_HALT;
                else
                    n = S_IF1;
            end
            S_GET_A:       n = (f.opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            S_GET_B:       n = S_ALU;
            S_ALU:         n = (f.opcode == OPC_ALU && f.op == OP_CMP) ? S_IF1 : S_WRITE_REG;
            S_ADDR:        n = S_LOAD_ADDR;
            S_LOAD_ADDR:   n = (f.opcode == OPC_LDR) ? S_MEM_RD : S_GET_RD;
            S_MEM_RD:      n = S_WRITE_MDATA;
            S_GET_RD:      n = S_STR_PASS;
            S_STR_PASS:    n = S_MEM_WR;
            S_WRITE_IMM,
            S_WRITE_REG,
            S_WRITE_MDATA,
            S_MEM_WR:      n = S_IF1;
            S_HALT:        n = S_HALT;
            default:       n = S_RST;
        endcase
        return n;
    endfunction

    function automatic ctrl_t ctrl_for(input state_t s, input instr_fields_t f);
        ctrl_t c;
        c = '0;
        case (s)
            S_RST: begin
                c.reset_pc = 1'b1;
                c.load_pc  = 1'b1;
            end
            S_IF1: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_RD;
            end
            S_IF2: begin
                c.addr_sel = 1'b1;
                c.mem_cmd  = MEM_RD;
                c.load_ir  = 1'b1;
            end
            S_UPDATE_PC: c.load_pc = 1'b1;
            S_WRITE_IMM: begin
                c.vsel     = VSEL_IMM;
                c.writenum = f.rn;
                c.write    = 1'b1;
            end
            S_GET_A: begin
                c.readnum = f.rn;
                c.loada   = 1'b1;
            end
            S_GET_B: begin
                c.readnum = f.rm;
                c.loadb   = 1'b1;
            end
            S_ALU: begin
                c.shift = f.sh;
                if (f.opcode == OPC_MOV) begin
                    c.asel  = 1'b1;
                    c.aluop = OP_ADD;
                    c.loadc = 1'b1;
                end else begin
                    c.aluop = f.op;
                    if (f.op == OP_CMP)
                        c.loads = 1'b1;
                    else
                        c.loadc = 1'b1;
                end
            end
            S_WRITE_REG: begin
                c.vsel     = VSEL_C;
                c.writenum = f.rd;
                c.write    = 1'b1;
            end
            S_ADDR: begin
                c.bsel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_LOAD_ADDR: c.load_addr = 1'b1;
            S_MEM_RD:    c.mem_cmd = MEM_RD;
            S_WRITE_MDATA: begin
                c.mem_cmd  = MEM_RD;
                c.vsel     = VSEL_MDATA;
                c.writenum = f.rd;
                c.write    = 1'b1;
            end
            S_GET_RD: begin
                c.readnum = f.rd;
                c.loadb   = 1'b1;
            end
            // instr[4:3] are immediate bits for STR, so the shifter stays idle
            S_STR_PASS: begin
                c.asel  = 1'b1;
                c.loadc = 1'b1;
            end
            S_MEM_WR: c.mem_cmd = MEM_WR;
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_RST;
            ctrl          <= '0;
            ctrl.reset_pc <= 1'b1;
            ctrl.load_pc  <= 1'b1;
        end else begin
            state <= next_state(state, fields);
            ctrl  <= ctrl_for(next_state(state, fields), fields);
        end
    end

    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign reset_pc  = ctrl.reset_pc;
    assign addr_sel  = ctrl.addr_sel;
    assign load_addr = ctrl.load_addr;
    assign mem_cmd   = ctrl.mem_cmd;
    assign vsel      = ctrl.vsel;
    assign writenum  = ctrl.writenum;
    assign readnum   = ctrl.readnum;
    assign write     = ctrl.write;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign shift     = ctrl.shift;
    assign ALUop     = ctrl.aluop;
    assign halted    = ctrl.halted;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: per-cycle expected control vectors are queued for each
// instruction and compared against the sequencer outputs on the falling edge.
module tb_datapath_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        load_ir, load_pc, reset_pc, addr_sel, load_addr;
    logic [1:0]  mem_cmd, vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;
    logic        halted;

    datapath_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .addr_sel  (addr_sel),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd),
        .vsel      (vsel),
        .writenum  (writenum),
        .readnum   (readnum),
        .write     (write),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .shift     (shift),
        .ALUop     (ALUop),
        .sximm5    (sximm5),
        .sximm8    (sximm8),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       load_ir, load_pc, reset_pc, addr_sel, load_addr;
        logic [1:0] mem_cmd, vsel;
        logic [2:0] writenum, readnum;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] shift, aluop;
        logic       halted;
    } ctl_t;

    ctl_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observe();
        ctl_t o;
        o = '{load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, vsel,
              writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel,
              shift, ALUop, halted};
        return o;
    endfunction

    function automatic ctl_t c_rst();
        ctl_t c = '0;
        c.reset_pc = 1'b1;
        c.load_pc  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_if1();
        ctl_t c = '0;
        c.addr_sel = 1'b1;
        c.mem_cmd  = 2'b01;
        return c;
    endfunction

    function automatic ctl_t c_get(input logic [2:0] r, input logic is_b);
        ctl_t c = '0;
        c.readnum = r;
        c.loada   = ~is_b;
        c.loadb   = is_b;
        return c;
    endfunction

    function automatic ctl_t c_alu(input logic [1:0] sh, input logic [1:0] op,
                                   input logic a, input logic b,
                                   input logic lc, input logic ls);
        ctl_t c = '0;
        c.shift = sh;
        c.aluop = op;
        c.asel  = a;
        c.bsel  = b;
        c.loadc = lc;
        c.loads = ls;
        return c;
    endfunction

    function automatic ctl_t c_write(input logic [1:0] vs, input logic [2:0] wn);
        ctl_t c = '0;
        c.vsel     = vs;
        c.writenum = wn;
        c.write    = 1'b1;
        return c;
    endfunction

    task automatic push_fetch();
        ctl_t c;
        c = c_if1();
        c.load_ir = 1'b1;
        q.push_back(c);
        c = '0;
        c.load_pc = 1'b1;
        q.push_back(c);
        q.push_back('0);
    endtask

    // Called at a falling edge in IF1; drains the queue one cycle per entry.
    task automatic run_instr(input string tag, input logic [15:0] iv, input int cpi);
        ctl_t e, o;
        int   n = 0;
        int   n_if1 = -1;
        instr = iv;
        while (q.size() > 0) begin
            @(negedge clk);
            n++;
            e = q.pop_front();
            o = observe();
            check_val($sformatf("%s_c%0d", tag, n), 32'(o), 32'(e));
            check_val($sformatf("%s_wrx%0d", tag, n), 32'(write && mem_cmd == 2'b10), 32'd0);
            if (n_if1 < 0 && o.addr_sel && o.mem_cmd == 2'b01 && !o.load_ir)
                n_if1 = n;
        end
        if (cpi > 0)
            check_val({tag, "_cpi"}, 32'(n_if1), 32'(cpi));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctl_t c;
        reset = 1'b1;
        instr = 16'h0000;
        @(negedge clk);
        check_val("rst", 32'(observe()), 32'(c_rst()));
        reset = 1'b0;
        q.push_back(c_if1());
        run_instr("rel", 16'h0000, 1);

        // MOV R2,#-1
        push_fetch();
        q.push_back(c_write(2'b10, 3'd2));
        q.push_back(c_if1());
        run_instr("movi", 16'hD2FF, 5);
        check_val("sx8", 32'(sximm8), 32'h0000FFFF);

        // ADD R2,R1,R0,LSL#1
        push_fetch();
        q.push_back(c_get(3'd1, 1'b0));
        q.push_back(c_get(3'd0, 1'b1));
        q.push_back(c_alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(c_write(2'b00, 3'd2));
        q.push_back(c_if1());
        run_instr("add", 16'hA148, 8);

        // CMP R1,R0
        push_fetch();
        q.push_back(c_get(3'd1, 1'b0));
        q.push_back(c_get(3'd0, 1'b1));
        q.push_back(c_alu(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1));
        q.push_back(c_if1());
        run_instr("cmp", 16'hA900, 7);

        // MOV R2,R1
        push_fetch();
        q.push_back(c_get(3'd1, 1'b1));
        q.push_back(c_alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
        q.push_back(c_write(2'b00, 3'd2));
        q.push_back(c_if1());
        run_instr("movr", 16'hC041, 7);

        // MVN R7,R1
        push_fetch();
        q.push_back(c_get(3'd1, 1'b1));
        q.push_back(c_alu(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0));
        q.push_back(c_write(2'b00, 3'd7));
        q.push_back(c_if1());
        run_instr("mvn", 16'hB8E1, 7);

        // opcode 000 is not an instruction: straight back to fetch
        push_fetch();
        q.push_back(c_if1());
        run_instr("nop", 16'h0000, 4);

        // Reset in the ALU cycle of an ADD
        push_fetch();
        q.push_back(c_get(3'd1, 1'b0));
        q.push_back(c_get(3'd0, 1'b1));
        q.push_back(c_alu(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
        run_instr("add_pre", 16'hA148, 0);
        #1 reset = 1'b1;
        #1 check_val("rst_async", 32'(observe()), 32'(c_rst()));
        check_val("rst_nowr", 32'(write), 32'd0);
        @(negedge clk);
        check_val("rst_hold", 32'(observe()), 32'(c_rst()));
        reset = 1'b0;
        q.push_back(c_if1());
        run_instr("rst_rel", 16'hA148, 1);

        // LDR R3,[R1,#-2]
        push_fetch();
        q.push_back(c_get(3'd1, 1'b0));
        q.push_back(c_alu(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
        c = '0;
        c.load_addr = 1'b1;
        q.push_back(c);
        c = '0;
        c.mem_cmd = 2'b01;
        q.push_back(c);
        c = c_write(2'b11, 3'd3);
        c.mem_cmd = 2'b01;
        q.push_back(c);
        q.push_back(c_if1());
        run_instr("ldr", 16'h617E, 9);
        check_val("sx5", 32'(sximm5), 32'h0000FFFE);

        // STR R3,[R1,#12]
        push_fetch();
        q.push_back(c_get(3'd1, 1'b0));
        q.push_back(c_alu(2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
        c = '0;
        c.load_addr = 1'b1;
        q.push_back(c);
        q.push_back(c_get(3'd3, 1'b1));
        q.push_back(c_alu(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0));
        c = '0;
        c.mem_cmd = 2'b10;
        q.push_back(c);
        q.push_back(c_if1());
        run_instr("str", 16'h816C, 10);
        check_val("sx5_str", 32'(sximm5), 32'h0000000C);

        // HALT holds with no enables
        push_fetch();
        c = '0;
        c.halted = 1'b1;
        for (int i = 0; i < 24; i++)
            q.push_back(c);
        run_instr("halt", 16'hE000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
